// File: rtl/iobus_uart_pkg.sv
// Shared types and register map for the IOBUS UART transmitter.
// UART_TX_PARITY_EN adds a PARITY state between DATA and STOP.
package iobus_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

    localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_DONE    = 4;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_W   = 5;

    localparam int CTRL_IE       = 0;
    localparam int CTRL_CLR_OVF  = 1;
    localparam int CTRL_CLR_DONE = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with first-word fall-through read; a push alongside a pop is
// always accepted, even when full.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [7:0]                   din,
    input  logic                         pop,
    output logic [7:0]                   dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the OTTER IOBUS (DATA/STATUS/CTRL).
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
import iobus_uart_pkg::*;

module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h1100_0100,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] IOBUS_IN,
    output logic        TX,
    output logic        INTR
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]       ADDR_DATA   = BASE_ADDR + OFF_DATA;
    localparam logic [31:0]       ADDR_STATUS = BASE_ADDR + OFF_STATUS;
    localparam logic [31:0]       ADDR_CTRL   = BASE_ADDR + OFF_CTRL;

    logic             wr_data;
    logic             wr_ctrl;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;

    tx_state_t        state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif
    logic             set_done;
    logic             ie_reg, ovf_reg, done_reg;
    logic             baud_end;
    logic [31:0]      status_word;
    logic             unused_wdata;

    assign wr_data  = IOBUS_WR && (IOBUS_ADDR == ADDR_DATA);
    assign wr_ctrl  = IOBUS_WR && (IOBUS_ADDR == ADDR_CTRL);
    assign baud_end = (baud_reg == BAUD_LAST);
    assign TX       = tx_reg;
    assign INTR     = ie_reg && done_reg;
    // Upper write-data bits have no register behind them.
    assign unused_wdata = ^IOBUS_OUT[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (RST),
        .push  (wr_data),
        .din   (IOBUS_OUT[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            ie_reg   <= 1'b0;
            ovf_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ie_reg <= IOBUS_OUT[CTRL_IE];
            end
            if (wr_data && fifo_full && !fifo_pop) begin
                ovf_reg <= 1'b1;
            end else if (wr_ctrl && IOBUS_OUT[CTRL_CLR_OVF]) begin
                ovf_reg <= 1'b0;
            end
            if (set_done) begin
                done_reg <= 1'b1;
            end else if (wr_data || (wr_ctrl && IOBUS_OUT[CTRL_CLR_DONE])) begin
                done_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        fifo_pop     = 1'b0;
        set_done     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                if (baud_end) begin
                    baud_next    = '0;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                    state_next   = ST_DATA;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        tx_next    = parity_reg;
                        state_next = ST_PARITY;
`else
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
`endif
                    end else begin
                        // Shift register keeps the next bit at position 1.
                        bit_idx_next = bit_idx_reg + 3'd1;
                        tx_next      = shift_reg[1];
                        shift_next   = {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    baud_next  = '0;
                    tx_next    = 1'b1;
                    state_next = ST_STOP;
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        tx_next    = 1'b0;
                        state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                        parity_next = ^fifo_dout;
`endif
                    end else begin
                        set_done   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase
    end

    always_comb begin
        status_word                = '0;
        status_word[STAT_BUSY]     = (state_reg != ST_IDLE) || !fifo_empty;
        status_word[STAT_FULL]     = fifo_full;
        status_word[STAT_EMPTY]    = fifo_empty;
        status_word[STAT_OVF]      = ovf_reg;
        status_word[STAT_DONE]     = done_reg;
        status_word[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        IOBUS_IN = '0;
        if (IOBUS_ADDR == ADDR_STATUS) begin
            IOBUS_IN = status_word;
        end else if (IOBUS_ADDR == ADDR_CTRL) begin
            IOBUS_IN[CTRL_IE] = ie_reg;
        end
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Scoreboard bench for iobus_uart_tx: stimulus queues expected frames, a serial
// monitor decodes TX and compares each frame against the queue head.
module tb_iobus_uart_tx;
    localparam logic [31:0] BASE = 32'h1100_0100;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME    = CPB * NBITS;
    localparam int STOP_POS = FRAME - CPB + CPB / 2;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] IOBUS_ADDR = '0;
    logic [31:0] IOBUS_OUT = '0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] IOBUS_IN;
    logic        TX;
    logic        INTR;

    iobus_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .IOBUS_IN   (IOBUS_IN),
        .TX         (TX),
        .INTR       (INTR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] data;
        int         exp_start;
        bit         abortable;
    } frame_t;
    frame_t sb[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cyc %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%08h (cyc %0d)", name, act, cyc);
        end
    endfunction

    function automatic void expect_frame(logic [7:0] d, int st, bit ab);
        frame_t f;
        f.data = d;
        f.exp_start = st;
        f.abortable = ab;
        sb.push_back(f);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        @(negedge clk);
        IOBUS_WR   = 1'b0;
        IOBUS_OUT  = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        IOBUS_ADDR = a;
        #1;
        d = IOBUS_IN;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Serial monitor: samples TX mid-bit on falling edges.
    initial begin : monitor
        bit         mbusy;
        int         pos;
        int         start_c;
        logic [7:0] rx;
        logic       start_bit;
        logic       par;
        frame_t     f;
        mbusy = 1'b0;
        pos = 0;
        start_c = 0;
        rx = '0;
        start_bit = 1'b0;
        par = 1'b0;
        forever begin
            @(negedge clk);
            if (RST) begin
                if (mbusy) begin
                    mbusy = 1'b0;
                    if (sb.size() > 0) begin
                        f = sb.pop_front();
                        check("frame_abort_allowed", 32'(f.abortable), 32'd1);
                    end else begin
                        check("abort_with_empty_queue", 32'd1, 32'd0);
                    end
                end
            end else if (!mbusy) begin
                if (TX === 1'b0) begin
                    mbusy = 1'b1;
                    pos = 0;
                    start_c = cyc;
                end
            end else begin
                pos++;
                if (pos == CPB / 2) begin
                    start_bit = TX;
                end else if (pos == STOP_POS) begin
                    mbusy = 1'b0;
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, expected no frame (cyc %0d)", rx, cyc);
                    end else begin
                        f = sb.pop_front();
                        check("frame_start_bit", 32'(start_bit), 32'd0);
                        check("frame_data", 32'(rx), 32'(f.data));
                        check("frame_stop_bit", 32'(TX), 32'd1);
                        if (f.exp_start >= 0)
                            check("frame_start_cycle", start_c, f.exp_start);
`ifdef UART_TX_PARITY_EN
                        check("frame_parity", 32'(par), 32'(^f.data));
`endif
                    end
                end else if (pos >= CPB + CPB / 2 && pos < 9 * CPB && (pos % CPB) == CPB / 2) begin
                    rx[(pos / CPB) - 1] = TX;
                end
`ifdef UART_TX_PARITY_EN
                else if (pos == 9 * CPB + CPB / 2) begin
                    par = TX;
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send_timed(input logic [7:0] d, input string tag);
        int w;
        logic [31:0] r;
        @(negedge clk);
        w = cyc;
        expect_frame(d, w + 2, 1'b0);
        wr(A_DATA, 32'(d));
        wait_until(w + 1 + FRAME);
        rd(A_STATUS, r);
        check({tag, "_done_before_end"}, 32'(r[4]), 32'd0);
        wait_until(w + 2 + FRAME);
        rd(A_STATUS, r);
        check({tag, "_done_at_end"}, 32'(r[4]), 32'd1);
    endtask

    logic [7:0] b2b [10] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                             8'h66, 8'h77, 8'h88, 8'h99, 8'hEE};

    initial begin : stimulus
        logic [31:0] r;
        int w;
        int seen_low;

        RST = 1'b1;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);

        rd(A_STATUS, r);  check("reset_status", r, 32'h0000_0004);
        check("reset_tx", 32'(TX), 32'd1);
        check("reset_intr", 32'(INTR), 32'd0);
        rd(A_CTRL, r);    check("reset_ctrl", r, 32'h0);
        rd(A_DATA, r);    check("read_data_addr_zero", r, 32'h0);
        rd(BASE + 32'hC, r); check("read_other_addr_zero", r, 32'h0);

        // Single frame 0xA5 with latency and done timing.
        @(negedge clk);
        w = cyc;
        expect_frame(8'hA5, w + 2, 1'b0);
        wr(A_DATA, 32'hA5);
        rd(A_STATUS, r);  check("status_after_push", r, 32'h0000_0101);
        wait_until(w + 1 + FRAME);
        rd(A_STATUS, r);  check("a5_done_before_end", 32'(r[4]), 32'd0);
        wait_until(w + 2 + FRAME);
        rd(A_STATUS, r);  check("a5_status_after_frame", r, 32'h0000_0014);

        // Ten back-to-back writes: nine frames, tenth dropped.
        @(negedge clk);
        w = cyc;
        for (int k = 0; k < 10; k++) begin
            if (k < 9) expect_frame(b2b[k], w + 2 + FRAME * k, 1'b0);
            wr(A_DATA, 32'(b2b[k]));
        end
        rd(A_STATUS, r);  check("status_overflow_full", r, 32'h0000_080B);
        wr(A_CTRL, 32'h2);
        rd(A_STATUS, r);  check("status_ovf_cleared", r & 32'h1F, 32'h0000_0003);
        for (int i = 0; i < 5000 && sb.size() > 0; i++) @(negedge clk);
        check("b2b_drained", sb.size(), 0);
        repeat (4) @(negedge clk);
        rd(A_STATUS, r);  check("status_after_drain", r, 32'h0000_0014);

        // Interrupt enable and clear.
        @(negedge clk);
        wr(A_CTRL, 32'h4);
        wr(A_CTRL, 32'h1);
        rd(A_CTRL, r);    check("ctrl_ie_set", r, 32'h1);
        check("intr_low_done_cleared", 32'(INTR), 32'd0);
        @(negedge clk);
        w = cyc;
        expect_frame(8'h00, w + 2, 1'b0);
        wr(A_DATA, 32'h0);
        wait_until(w + 1 + FRAME);
        check("intr_before_stop_end", 32'(INTR), 32'd0);
        wait_until(w + 2 + FRAME);
        check("intr_at_stop_end", 32'(INTR), 32'd1);
        @(negedge clk);
        wr(A_CTRL, 32'h5);
        check("intr_cleared", 32'(INTR), 32'd0);
        rd(A_CTRL, r);    check("ctrl_ie_kept", r, 32'h1);

`ifdef UART_TX_PARITY_EN
        send_timed(8'h07, "par07");
        send_timed(8'h03, "par03");
`else
        send_timed(8'h5A, "plain5a");
`endif

        // Reset in the middle of data bit 3 (0xC3 has bit3 = 0).
        @(negedge clk);
        w = cyc;
        expect_frame(8'hC3, w + 2, 1'b1);
        wr(A_DATA, 32'hC3);
        wait_until(w + 19);
        check("tx_bit3_before_rst", 32'(TX), 32'd0);
        #1 RST = 1'b1;
        #1 check("tx_high_on_rst", 32'(TX), 32'd1);
        check("intr_low_on_rst", 32'(INTR), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        rd(A_STATUS, r);  check("status_after_rst", r, 32'h0000_0004);
        check("aborted_frame_consumed", sb.size(), 0);
        seen_low = 0;
        repeat (100) begin
            @(negedge clk);
            if (TX !== 1'b1) seen_low++;
        end
        check("no_frame_after_rst", seen_low, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iobus_uart_tx.md
# iobus_uart_tx

Memory-mapped 8N1 UART transmitter that responds on the OTTER IOBUS: the CPU drives address, write data and write strobe, and this block returns status on the read-data path. Bytes written by the CPU are queued in a small FIFO and shifted out LSB-first on a serial line. A sticky completion flag drives the CPU interrupt input. The block sits beside the MCU in the top level, with its read data ORed or muxed into `CPU_IOBUS_IN`.

## Interface
- `BASE_ADDR`, 32'h1100_0100, word-aligned base of the three registers
- `CLKS_PER_BIT`, 868, clock cycles per serial bit (≥2)
- `FIFO_DEPTH`, 8, byte FIFO depth; power of two, 2..16
- `clk`  in  1  system clock; all state on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `IOBUS_ADDR`  in  32  CPU IOBUS address
- `IOBUS_OUT`  in  32  CPU write data
- `IOBUS_WR`  in  1  CPU write strobe, one cycle per store
- `IOBUS_IN`  out  32  read data, combinational from `IOBUS_ADDR`
- `TX`  out  1  serial line, registered, idle high
- `INTR`  out  1  interrupt request to `CPU_INTR`, level

## Operation
- Registers, full 32-bit address compare:
  - `BASE+0` DATA (W): `IOBUS_OUT[7:0]` pushed to the FIFO.
  - `BASE+4` STATUS (R): bit0 busy, bit1 full, bit2 empty, bit3 overflow (sticky), bit4 done (sticky), bits[12:8] FIFO count.
  - `BASE+8` CTRL (R/W): bit0 IE (stored, reads back). Write-1 to bit1 clears overflow; write-1 to bit2 clears done. Bits 1 and 2 read as 0.
- Reads of any other address return 0. Writes to other addresses are ignored.
- busy = (state ≠ IDLE) | !empty.
- A push while full is dropped and sets overflow. A push in the same cycle as a pop is always accepted, and count is unchanged.
- Transmitter FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if the FIFO is not empty, pop into the shift register, TX←0, go to START.
  - START, DATA and each bit of STOP last `CLKS_PER_BIT` cycles, counted by the baud counter.
  - DATA: 8 bits, LSB first, tracked by a 3-bit index.
  - STOP: TX←1. At the end of STOP: if the FIFO is not empty, pop directly into START (back-to-back frames with no idle gap); else go to IDLE and set done.
- done is cleared by a CTRL bit2 write or by any DATA write. If a clear and a set happen in the same cycle, set wins.
- INTR = IE & done.
- Reset values: TX=1, INTR=0, `IOBUS_IN` follows address decode (STATUS reads 0x0000_0004), FIFO empty, IE=0, overflow=0, done=0, state IDLE.
- RST asserted mid-frame aborts the frame immediately. The FIFO is discarded and TX returns high asynchronously.

## Timing
- DATA write sampled at edge N with the FIFO empty and state IDLE: count=1 after N; pop at N+1, TX low from N+1.
- Frame length is 10·`CLKS_PER_BIT` cycles, or 11· with parity.
- done sets at the edge that ends the final stop bit. INTR follows in the same cycle, since it is combinational from registers.
- Baud counter width is $clog2(`CLKS_PER_BIT`). Count width is $clog2(`FIFO_DEPTH`+1).

## Configuration
- `UART_TX_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for one bit time.
- `UART_TX_PARITY_EN` undefined: plain 8N1, no PARITY state in the enum.

## Structure
- Package `iobus_uart_pkg` holds:
  - the state enum (PARITY under the macro);
  - register offset constants (DATA 0, STATUS 4, CTRL 8);
  - STATUS/CTRL bit-position constants.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop/full/empty/count and async reset. The top level contains decode, status/ctrl, and the FSM.

## Test plan
Bench uses `CLKS_PER_BIT`=4, `FIFO_DEPTH`=8.
- Reset, then read `BASE+4` → 0x0000_0004; TX=1; INTR=0.
- Write 0xA5 to `BASE` → TX low one cycle later for 4 cycles. Then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high. Total 40 cycles; afterwards STATUS bit4=1.
- 10 back-to-back DATA writes → 9 frames transmitted with no idle gaps; STATUS bit3=1 and bit1=1 right after the 10th write. A CTRL write of 0x2 then clears bit3.
- CTRL write 0x1, then DATA write 0x00 → INTR rises at the end of the stop bit. CTRL write 0x5 → INTR low next cycle, IE remains 1.
- RST pulsed during data bit 3 → TX=1 immediately; STATUS=0x04 after release; no further frame.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit 1, frame 44 cycles. Write 0x03 → parity bit 0.
